// File: rtl/plab4_net_router_output_sched_pkg.sv
// Shared constants for the ring-router output scheduler: input port indices
// and the credit-counter width helper.
package plab4_net_router_output_sched_pkg;

  localparam int unsigned SCHED_PORT_PREV = 0;
  localparam int unsigned SCHED_PORT_TERM = 1;
  localparam int unsigned SCHED_PORT_NEXT = 2;
  localparam int unsigned SCHED_NUM_PORTS = 3;

  localparam int unsigned SCHED_DEFAULT_CREDITS = 2;

  // Width needed to hold a credit count in the range 0..n inclusive.
  function automatic int unsigned credit_nbits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/plab4_net_router_output_sched_arb.sv
// Round-robin arbiter: one-hot priority pointer plus rotate-priority grant
// logic; the winner becomes lowest priority on the next arbitration.
module plab4_net_router_output_sched_arb #(
  parameter int unsigned p_nbits = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [p_nbits-1:0] reqs,
  output logic [p_nbits-1:0] grants
);

  logic [p_nbits-1:0] prio;
  logic [p_nbits-1:0] reqs_hi;
  logic [p_nbits-1:0] pick_hi;
  logic [p_nbits-1:0] pick_all;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    reqs_hi  = reqs & ~(prio - p_nbits'(1));
    pick_hi  = reqs_hi & (~reqs_hi + p_nbits'(1));
    pick_all = reqs & (~reqs + p_nbits'(1));
    grants   = '0;
    if (en) begin
      grants = (reqs_hi != '0) ? pick_hi : pick_all;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= p_nbits'(1);
    end else if (grants != '0) begin
      prio <= {grants[p_nbits-2:0], grants[p_nbits-1]};
    end
  end

endmodule

// File: rtl/plab4_net_router_output_sched.sv
// Per-output-port scheduler: round-robin among input controllers, gated by
// downstream credits, exporting the free-slot count for bubble flow control.
module plab4_net_router_output_sched
  import plab4_net_router_output_sched_pkg::*;
#(
  parameter int unsigned p_num_reqs    = SCHED_NUM_PORTS,
  parameter int unsigned p_num_credits = SCHED_DEFAULT_CREDITS
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [p_num_reqs-1:0]                     reqs,
  output logic [p_num_reqs-1:0]                     grants,
  output logic                                      out_val,
  input  logic                                      out_rdy,
  input  logic                                      credit_return,
  output logic [credit_nbits(p_num_credits)-1:0]    num_free,
  output logic                                      credit_err
);

  localparam int unsigned c_credit_nbits = credit_nbits(p_num_credits);
  localparam logic [c_credit_nbits-1:0] c_credit_max = c_credit_nbits'(p_num_credits);

  logic [c_credit_nbits-1:0] credits;
  logic                      eligible;
  logic                      fire;

  assign eligible = (credits != '0) && out_rdy && !reset;

  plab4_net_router_output_sched_arb #(
    .p_nbits (p_num_reqs)
  ) arb (
    .clk    (clk),
    .reset  (reset),
    .en     (eligible),
    .reqs   (reqs),
    .grants (grants)
  );

  assign out_val  = |grants;
  assign fire     = out_val;
  assign num_free = credits;

  // Credit counter: a send and a return in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits    <= c_credit_max;
      credit_err <= 1'b0;
    end else if (fire && !credit_return) begin
      if (credits == '0) begin
        credit_err <= 1'b1;
      end else begin
        credits <= credits - c_credit_nbits'(1);
      end
    end else if (!fire && credit_return) begin
      if (credits == c_credit_max) begin
        credit_err <= 1'b1;
      end else begin
        credits <= credits + c_credit_nbits'(1);
      end
    end
  end

  no_underflow: assert property (@(posedge clk) disable iff (reset)
                                 !(fire && !credit_return && credits == '0));

endmodule

// File: tb/tb_plab4_net_router_output_sched.sv
// Directed bench for the output scheduler: arbitration order, credit
// gating/return timing, overflow error and asynchronous reset.
module tb_plab4_net_router_output_sched;

  logic       clk;
  logic       reset;
  logic [2:0] reqs;
  logic [2:0] grants;
  logic       out_val;
  logic       out_rdy;
  logic       credit_return;
  logic [1:0] num_free;
  logic       credit_err;

  int checks;
  int errors;

  plab4_net_router_output_sched dut (
    .clk           (clk),
    .reset         (reset),
    .reqs          (reqs),
    .grants        (grants),
    .out_val       (out_val),
    .out_rdy       (out_rdy),
    .credit_return (credit_return),
    .num_free      (num_free),
    .credit_err    (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic [2:0] g, input logic [1:0] nf,
                           input logic err);
    @(negedge clk);
    chk({tag, "_grants"}, 32'(grants), 32'(g));
    chk({tag, "_out_val"}, 32'(out_val), 32'(|g));
    chk({tag, "_num_free"}, 32'(num_free), 32'(nf));
    chk({tag, "_credit_err"}, 32'(credit_err), 32'(err));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    reset = 1'b1;
    reqs = 3'b000;
    out_rdy = 1'b0;
    credit_return = 1'b0;

    // Reset held with requests pending: nothing granted.
    #2;
    reqs = 3'b111;
    out_rdy = 1'b1;
    #1;
    chk("in_reset_grants", 32'(grants), 32'h0);
    reqs = 3'b000;
    out_rdy = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    chk_cycle("idle", 3'b000, 2'd2, 1'b0);

    // Round robin with all requesting; returns keep credits at 1.
    next_cycle();
    reqs = 3'b111; out_rdy = 1'b1; credit_return = 1'b0;
    chk_cycle("rr0", 3'b001, 2'd2, 1'b0);
    next_cycle(); credit_return = 1'b1;
    chk_cycle("rr1", 3'b010, 2'd1, 1'b0);
    next_cycle();
    chk_cycle("rr2", 3'b100, 2'd1, 1'b0);
    next_cycle();
    chk_cycle("rr3", 3'b001, 2'd1, 1'b0);
    next_cycle(); reqs = 3'b000;
    chk_cycle("rr_drain", 3'b000, 2'd1, 1'b0);
    next_cycle(); credit_return = 1'b0;
    chk_cycle("rr_refill", 3'b000, 2'd2, 1'b0);

    // Single requester exhausts credits (prio is 010 here).
    next_cycle(); reqs = 3'b010;
    chk_cycle("ex0", 3'b010, 2'd2, 1'b0);
    next_cycle();
    chk_cycle("ex1", 3'b010, 2'd1, 1'b0);
    next_cycle();
    chk_cycle("ex2", 3'b000, 2'd0, 1'b0);

    // Credit return at zero enables a grant only on the following cycle.
    next_cycle(); reqs = 3'b001; credit_return = 1'b1;
    chk_cycle("ret_n", 3'b000, 2'd0, 1'b0);
    next_cycle(); credit_return = 1'b0;
    chk_cycle("ret_n1", 3'b001, 2'd1, 1'b0);
    next_cycle();
    chk_cycle("ret_n2", 3'b000, 2'd0, 1'b0);
    next_cycle(); reqs = 3'b000; credit_return = 1'b1;
    next_cycle();
    next_cycle(); credit_return = 1'b0;
    chk_cycle("ret_refill", 3'b000, 2'd2, 1'b0);

    // out_rdy low blocks the grant and leaves prio (010) untouched.
    next_cycle(); reqs = 3'b100; out_rdy = 1'b0;
    chk_cycle("rdy_low", 3'b000, 2'd2, 1'b0);
    next_cycle(); out_rdy = 1'b1;
    chk_cycle("rdy_high", 3'b100, 2'd2, 1'b0);
    next_cycle(); reqs = 3'b000; credit_return = 1'b1;
    chk_cycle("rdy_ret", 3'b000, 2'd1, 1'b0);

    // Overflow: return with a full counter saturates and sets a sticky error.
    next_cycle();
    chk_cycle("ovf0", 3'b000, 2'd2, 1'b0);
    next_cycle(); credit_return = 1'b0;
    chk_cycle("ovf1", 3'b000, 2'd2, 1'b1);
    next_cycle();
    chk_cycle("ovf_sticky", 3'b000, 2'd2, 1'b1);

    // Drain to credits=0, prio=100, then reset mid-cycle.
    next_cycle(); reqs = 3'b111;
    chk_cycle("pre0", 3'b001, 2'd2, 1'b1);
    next_cycle();
    chk_cycle("pre1", 3'b010, 2'd1, 1'b1);
    next_cycle();
    chk_cycle("pre2", 3'b000, 2'd0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_grants", 32'(grants), 32'h0);
    chk("mid_reset_num_free", 32'(num_free), 32'h2);
    chk("mid_reset_err", 32'(credit_err), 32'h0);
    next_cycle(); reset = 1'b0;
    chk_cycle("post_reset0", 3'b001, 2'd2, 1'b0);
    next_cycle();
    chk_cycle("post_reset1", 3'b010, 2'd1, 1'b0);

    next_cycle(); reqs = 3'b000;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
